// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity selectors and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    // Widest word the helper accepts; narrower words are zero-extended, which
    // leaves their XOR reduction unchanged.
    localparam int PARITY_DATA_W = 32;

    function automatic logic uart_parity(input logic [PARITY_DATA_W-1:0] data,
                                         input logic                     parity_type);
        return (parity_type == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, UART_SIZE data bits LSB first, optional parity,
// STOP_BITS stop bits. Bit timing comes from an external phase accumulator.
module uart_tx #(
    parameter int UART_SIZE = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    output logic                 phase_accum_reset,
    input  logic [UART_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_enable,
    input  logic                 parity_type,
    output logic                 TX,
    output logic                 busy,
    output logic                 done
);
    import uart_pkg::*;

    localparam int               CNT_W     = $clog2(UART_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(UART_SIZE - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state;
    logic [UART_SIZE-1:0] shift_reg;
    logic [UART_SIZE-1:0] shift_next;
    logic                 parity_en_q;
    logic                 parity_bit_q;
    logic [CNT_W-1:0]     bit_count;
    logic                 stop_count;
    logic                 accept;

    assign accept     = tx_valid && tx_ready;
    assign shift_next = shift_reg >> 1;

    // NOTE: every register here is updated with <= so all state moves together
    // on the edge and reads in this block see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            TX                <= 1'b1;
            phase_accum_reset <= 1'b1;
            tx_ready          <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            shift_reg         <= '0;
            parity_en_q       <= 1'b0;
            parity_bit_q      <= 1'b0;
            bit_count         <= '0;
            stop_count        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // baud_tick is deliberately ignored here; an accept wins.
                    if (accept) begin
                        shift_reg         <= tx_data;
                        parity_en_q       <= parity_enable;
                        parity_bit_q      <= uart_parity(PARITY_DATA_W'(tx_data), parity_type);
                        TX                <= 1'b0;
                        phase_accum_reset <= 1'b0;
                        tx_ready          <= 1'b0;
                        busy              <= 1'b1;
                        state             <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        TX        <= shift_reg[0];
                        bit_count <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_count < LAST_DATA) begin
                            shift_reg <= shift_next;
                            TX        <= shift_next[0];
                            bit_count <= bit_count + 1'b1;
                        end else if (parity_en_q) begin
                            TX    <= parity_bit_q;
                            state <= PARITY;
                        end else begin
                            TX         <= 1'b1;
                            stop_count <= 1'b0;
                            state      <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        TX         <= 1'b1;
                        stop_count <= 1'b0;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_count == STOP_LAST) begin
                            done              <= 1'b1;
                            busy              <= 1'b0;
                            tx_ready          <= 1'b1;
                            phase_accum_reset <= 1'b1;
                            state             <= IDLE;
                        end else begin
                            stop_count <= stop_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state             <= IDLE;
                    TX                <= 1'b1;
                    phase_accum_reset <= 1'b1;
                    tx_ready          <= 1'b1;
                    busy              <= 1'b0;
                    bit_count         <= '0;
                    stop_count        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected frames, line
// monitors that sample mid-bit, plus directed reset and handshake checks.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        int         stops;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;

    logic       tick1, par1, ready1, valid1, pen1, ptype1, tx1, busy1, done1;
    logic [7:0] data1;
    logic       tick2, par2, ready2, valid2, pen2, ptype2, tx2, busy2, done2;
    logic [7:0] data2;
    logic [3:0] acc1, acc2;

    frame_t     q1[$];
    frame_t     q2[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt1 = 0;
    int         done_cnt2 = 0;
    logic       prev_done1 = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.UART_SIZE(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .baud_tick(tick1), .phase_accum_reset(par1),
        .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
        .parity_enable(pen1), .parity_type(ptype1),
        .TX(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.UART_SIZE(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .baud_tick(tick2), .phase_accum_reset(par2),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
        .parity_enable(pen2), .parity_type(ptype2),
        .TX(tx2), .busy(busy2), .done(done2)
    );

    // Phase accumulator model: one tick every 16 clocks once released.
    always @(posedge clk) begin
        acc1 <= par1 ? 4'd0 : acc1 + 4'd1;
        acc2 <= par2 ? 4'd0 : acc2 + 4'd1;
    end
    assign tick1 = !par1 && (acc1 == 4'd15);
    assign tick2 = !par2 && (acc2 == 4'd15);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic exp_parity(input logic [7:0] d, input logic even);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return even ? (ones % 2 == 1) : (ones % 2 == 0);
    endfunction

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx1 : tx2;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done1 : done2;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel == 0) ? ready1 : ready2;
    endfunction

    always @(negedge clk) begin
        if (done1) begin
            done_cnt1++;
            check("done1_width", prev_done1, 1'b0);
        end
        if (done2) done_cnt2++;
        prev_done1 = done1;
    end

    task automatic monitor(input int sel);
        frame_t f;
        int     waited;
        bit     empty;
        forever begin
            @(negedge clk);
            if (tx_of(sel) !== 1'b0) continue;
            empty = (sel == 0) ? (q1.size() == 0) : (q2.size() == 0);
            if (empty) begin
                while (tx_of(sel) === 1'b0) @(negedge clk);
                continue;
            end
            f = (sel == 0) ? q1.pop_front() : q2.pop_front();
            repeat (7) @(negedge clk);
            check($sformatf("m%0d_start", sel), tx_of(sel), 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(negedge clk);
                check($sformatf("m%0d_data%0d_%02h", sel, i, f.data), tx_of(sel), f.data[i]);
            end
            if (f.par_en) begin
                repeat (16) @(negedge clk);
                check($sformatf("m%0d_parity_%02h", sel, f.data), tx_of(sel), f.par_bit);
            end
            for (int s = 0; s < f.stops; s++) begin
                repeat (16) @(negedge clk);
                check($sformatf("m%0d_stop%0d", sel, s), tx_of(sel), 1'b1);
            end
            waited = 0;
            while (done_of(sel) !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("m%0d_done_latency", sel), waited, 9);
            check($sformatf("m%0d_ready_with_done", sel), ready_of(sel), 1'b1);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic push_exp(input int sel, input logic [7:0] d, input logic pen, input logic pt);
        frame_t f;
        f.data    = d;
        f.par_en  = pen;
        f.par_bit = exp_parity(d, pt);
        f.stops   = (sel == 0) ? 1 : 2;
        if (sel == 0) q1.push_back(f);
        else          q2.push_back(f);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic pen,
                        input logic pt, input bit push);
        int w = 0;
        @(negedge clk);
        while (ready_of(sel) !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check("send_ready_timeout", 1'b0, 1'b1);
        if (sel == 0) begin
            data1 = d; pen1 = pen; ptype1 = pt; valid1 = 1'b1;
        end else begin
            data2 = d; pen2 = pen; ptype2 = pt; valid2 = 1'b1;
        end
        if (push) push_exp(sel, d, pen, pt);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int w = 0;
        while (done_of(sel) !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check("done_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid1 = 1'b0; data1 = '0; pen1 = 1'b0; ptype1 = 1'b0;
        valid2 = 1'b0; data2 = '0; pen2 = 1'b0; ptype2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx1, 1'b1);
        check("rst_par", par1, 1'b1);
        check("rst_ready", ready1, 1'b1);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5, then even/odd parity on 0x07
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_busy", busy1, 1'b1);
        check("a5_ready_low", ready1, 1'b0);
        check("a5_accum_run", par1, 1'b0);
        wait_done(0);
        send(0, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_done(0);
        send(0, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_done(0);

        // parity config and data changed mid-frame must not matter
        send(0, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        ptype1 = 1'b0; pen1 = 1'b0; data1 = 8'hF0;
        wait_done(0);

        // two stop bits on the second instance
        send(1, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_done(1);

        // tx_valid held high across two frames
        @(negedge clk);
        data1 = 8'h55; pen1 = 1'b0; ptype1 = 1'b0; valid1 = 1'b1;
        push_exp(0, 8'h55, 1'b0, 1'b0);
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        data1 = 8'h3C;
        repeat (50) @(negedge clk);
        check("held_ready_mid", ready1, 1'b0);
        begin
            int w = 0;
            while (done1 !== 1'b1 && w < 400) begin
                @(negedge clk);
                w++;
            end
            check("held_first_done_seen", done1, 1'b1);
        end
        check("held_busy_at_done", busy1, 1'b0);
        @(posedge clk);
        #1;
        check("held_second_accept_busy", busy1, 1'b1);
        check("held_second_accept_tx", tx1, 1'b0);
        valid1 = 1'b0;
        wait_done(0);

        // reset during the 4th data bit abandons the frame
        send(0, 8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (70) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", tx1, 1'b1);
        check("abort_busy", busy1, 1'b0);
        check("abort_ready", ready1, 1'b1);
        check("abort_par", par1, 1'b1);
        check("abort_done", done1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_done(0);

        repeat (5) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        check("done1_count", done_cnt1, 7);
        check("done2_count", done_cnt2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
